// File: rtl/sram_8x512_arb.sv
// rtl/sram_8x512_arb.sv - two-requester round-robin front end for a 1-port SRAM
// Optional power-up clear, then one grant per cycle with 1-cycle read responses.
module sram_8x512_arb #(
    parameter int BITS       = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_DEPTH = 512,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_v_i,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [BITS-1:0]       req0_wd_i,
    input  logic [BITS-1:0]       req0_mask_i,
    output logic                  req0_ready_o,
    input  logic                  req1_v_i,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [BITS-1:0]       req1_wd_i,
    input  logic [BITS-1:0]       req1_mask_i,
    output logic                  req1_ready_o,
    output logic                  rsp0_v_o,
    output logic                  rsp1_v_o,
    output logic [BITS-1:0]       rsp_data_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [BITS-1:0]       sram_wd_o,
    output logic [BITS-1:0]       sram_mask_o,
    input  logic [BITS-1:0]       sram_rd_i,
    output logic                  init_done_o
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t                RESET_STATE = (INIT_CLEAR != 0) ? INIT : RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp0_v_q, rsp0_v_d;
    logic                  rsp1_v_q, rsp1_v_d;
    logic                  grant0, grant1;

    // Reset is folded in so that nothing reaches the SRAM while reset_n is low.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && (state_q == RUN)) begin
            if (req0_v_i && (!req1_v_i || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (req1_v_i) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        sram_ce_o   = 1'b0;
        sram_we_o   = 1'b0;
        sram_addr_o = '0;
        sram_wd_o   = '0;
        sram_mask_o = '0;
        if (reset_n && (state_q == INIT)) begin
            sram_ce_o   = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = init_cnt_q;
            sram_mask_o = '1;
        end else if (grant0) begin
            sram_ce_o   = 1'b1;
            sram_we_o   = req0_we_i;
            sram_addr_o = req0_addr_i;
            sram_wd_o   = req0_wd_i;
            sram_mask_o = req0_mask_i;
        end else if (grant1) begin
            sram_ce_o   = 1'b1;
            sram_we_o   = req1_we_i;
            sram_addr_o = req1_addr_i;
            sram_wd_o   = req1_wd_i;
            sram_mask_o = req1_mask_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        last_grant_d = last_grant_q;
        rsp0_v_d     = grant0 && !req0_we_i;
        rsp1_v_d     = grant1 && !req1_we_i;
        if (state_q == INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
                init_cnt_d = '0;
                state_d    = RUN;
            end
        end
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RESET_STATE;
            init_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rsp0_v_q     <= 1'b0;
            rsp1_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            last_grant_q <= last_grant_d;
            rsp0_v_q     <= rsp0_v_d;
            rsp1_v_q     <= rsp1_v_d;
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign rsp0_v_o     = rsp0_v_q;
    assign rsp1_v_o     = rsp1_v_q;
    assign rsp_data_o   = sram_rd_i;
    assign init_done_o  = reset_n && (state_q == RUN);

endmodule

// File: tb/tb_sram_8x512_arb.sv
// tb/tb_sram_8x512_arb.sv - self-checking bench for sram_8x512_arb
// Behavioural SRAM + reference memory; directed scenarios then random traffic.
module tb_sram_8x512_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       r0_v, r0_we, r1_v, r1_we;
    logic [8:0] r0_a, r1_a;
    logic [7:0] r0_d, r0_m, r1_d, r1_m;
    logic       rdy0, rdy1, rsp0_v, rsp1_v, s_ce, s_we, done;
    logic [7:0] rsp_data, s_wd, s_mask, s_rd;
    logic [8:0] s_addr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sram_mem [512];
    logic [7:0] ref_mem  [512];
    logic       exp_last;
    int         last_win;
    logic [7:0] last_rsp_data;

    always #5 clk = ~clk;

    sram_8x512_arb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_v_i     (r0_v),
        .req0_we_i    (r0_we),
        .req0_addr_i  (r0_a),
        .req0_wd_i    (r0_d),
        .req0_mask_i  (r0_m),
        .req0_ready_o (rdy0),
        .req1_v_i     (r1_v),
        .req1_we_i    (r1_we),
        .req1_addr_i  (r1_a),
        .req1_wd_i    (r1_d),
        .req1_mask_i  (r1_m),
        .req1_ready_o (rdy1),
        .rsp0_v_o     (rsp0_v),
        .rsp1_v_o     (rsp1_v),
        .rsp_data_o   (rsp_data),
        .sram_ce_o    (s_ce),
        .sram_we_o    (s_we),
        .sram_addr_o  (s_addr),
        .sram_wd_o    (s_wd),
        .sram_mask_o  (s_mask),
        .sram_rd_i    (s_rd),
        .init_done_o  (done)
    );

    // External single-port SRAM with a one-cycle read latency.
    always @(posedge clk) begin
        if (s_ce) begin
            if (s_we) sram_mem[s_addr] <= (sram_mem[s_addr] & ~s_mask) | (s_wd & s_mask);
            else      s_rd <= sram_mem[s_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds reset across a posedge, releases at a negedge, then checks every clear cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({s_ce, s_we, s_addr, s_wd, s_mask, rdy0, rdy1, rsp0_v, rsp1_v, done}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            #1;
            chk("init_cycle", 32'({s_ce, s_we, s_addr, s_wd, s_mask, rdy0, rdy1, done}),
                32'({1'b1, 1'b1, 9'(i), 8'h00, 8'hFF, 3'b000}));
            @(negedge clk);
        end
        #1;
        chk("init_done", 32'(done), 32'd1);
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        exp_last = 1'b1;
        @(negedge clk);
    endtask

    // One command cycle starting at a negedge; ends at the following negedge.
    task automatic cyc(input logic v0, input logic we0, input logic [8:0] a0,
                       input logic [7:0] d0, input logic [7:0] m0,
                       input logic v1, input logic we1, input logic [8:0] a1,
                       input logic [7:0] d1, input logic [7:0] m1);
        int         win;
        logic       w_we;
        logic [8:0] w_a;
        logic [7:0] w_d, w_m, ed;
        logic       e0, e1;
        r0_v = v0; r0_we = we0; r0_a = a0; r0_d = d0; r0_m = m0;
        r1_v = v1; r1_we = we1; r1_a = a1; r1_d = d1; r1_m = m1;
        #1;
        if (v0 && v1)  win = exp_last ? 0 : 1;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
        else           win = -1;
        w_we = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
        w_a  = (win == 0) ? a0  : (win == 1) ? a1  : 9'd0;
        w_d  = (win == 0) ? d0  : (win == 1) ? d1  : 8'd0;
        w_m  = (win == 0) ? m0  : (win == 1) ? m1  : 8'd0;
        chk("ready0", 32'(rdy0), 32'(win == 0));
        chk("ready1", 32'(rdy1), 32'(win == 1));
        chk("sram_ce", 32'(s_ce), 32'(win >= 0));
        chk("sram_cmd", 32'({s_we, s_addr, s_wd, s_mask}), 32'({w_we, w_a, w_d, w_m}));
        e0 = (win == 0) && !we0;
        e1 = (win == 1) && !we1;
        ed = ref_mem[w_a];
        if (win >= 0) begin
            if (w_we) ref_mem[w_a] = (ref_mem[w_a] & ~w_m) | (w_d & w_m);
            exp_last = (win == 1);
        end
        last_win = win;
        @(posedge clk);
        #1;
        chk("rsp0_v", 32'(rsp0_v), 32'(e0));
        chk("rsp1_v", 32'(rsp1_v), 32'(e1));
        if (e0 || e1) chk("rsp_data", 32'(rsp_data), 32'(ed));
        last_rsp_data = rsp_data;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] ra;
        reset_n = 1'b0;
        r0_v = 0; r0_we = 0; r0_a = 0; r0_d = 0; r0_m = 0;
        r1_v = 0; r1_we = 0; r1_a = 0; r1_d = 0; r1_m = 0;
        exp_last = 1'b1;
        @(negedge clk);

        // Requester 1 holds a read through the whole clear sequence.
        r1_v = 1'b1; r1_we = 1'b0; r1_a = 9'h123;
        do_reset();
        cyc(1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 1'b1, 1'b0, 9'h123, 8'd0, 8'd0);
        chk("init_first_run_grant", 32'(last_win), 32'd1);
        chk("cleared_word", 32'(last_rsp_data), 32'h00);
        for (int i = 0; i < 4; i++) begin
            ra = 9'($urandom_range(0, 511));
            cyc(1'b1, 1'b0, ra, 8'd0, 8'd0, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0);
        end

        cyc(1'b1, 1'b1, 9'h1A5, 8'h3C, 8'hFF, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0);
        cyc(1'b1, 1'b0, 9'h1A5, 8'h00, 8'h00, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0);
        chk("rd_1a5", 32'(last_rsp_data), 32'h3C);

        cyc(1'b1, 1'b1, 9'h0F0, 8'hAA, 8'hFF, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 1'b1, 1'b1, 9'h0F0, 8'h55, 8'h0F);
        cyc(1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 1'b1, 1'b0, 9'h0F0, 8'h00, 8'h00);
        chk("masked_merge", 32'(last_rsp_data), 32'hA5);
        idle();

        // Continuous tie straight out of reset must alternate starting with requester 0.
        r0_v = 1'b0; r1_v = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, i[0], 9'(16 + i), 8'(i * 17), 8'hFF, 1'b1, 1'b0, 9'(16 + i), 8'd0, 8'd0);
            chk("alt_grant", 32'(last_win), 32'(i % 2));
        end

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
                8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
                8'($urandom), 8'($urandom));
        end

        // Reset arrives while a granted read's response is due; it must be dropped.
        r0_v = 1'b1; r0_we = 1'b0; r0_a = 9'h005;
        r1_v = 1'b0;
        #1;
        chk("pre_abort_ready0", 32'(rdy0), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_rsp", 32'({rsp0_v, rsp1_v, done, s_ce}), 32'd0);
        r0_v = 1'b0;
        do_reset();
        cyc(1'b1, 1'b0, 9'h005, 8'd0, 8'd0, 1'b1, 1'b0, 9'h006, 8'd0, 8'd0);
        chk("post_reset_tie", 32'(last_win), 32'd0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
